vga_sequenceur: RTL and testbench

- Sequences the VGA pixel pipeline for 640x480 at 60 Hz.
- Generates the hpos/vpos raster counters that drive the drawing layers (cadre, briques, raquette, balle).
- Arbitrates the layers' 5-bit colours into a single registered pixel colour, aligned with hsync/vsync.
- Emits a one-cycle fin_trame pulse at the start of vertical blanking so game logic updates off-screen.

---
 rtl/vga_pkg.sv | 44 ++++
 rtl/vga_compteurs.sv | 62 ++++++
 rtl/vga_sequenceur.sv | 132 +++++++++++++
 tb/tb_vga_sequenceur.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants, colour constants, layer indices and the
// layer priority function used by the VGA sequencer (vga_sequenceur).
package vga_pkg;

  // 640x480 @ 60 Hz timing defaults
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  typedef logic [4:0] couleur_t;

  localparam couleur_t NOIR        = 5'b00000;
  localparam couleur_t TRANSPARENT = 5'b00000;
  localparam couleur_t JAUNE       = 5'b11000;
  localparam couleur_t BLANC       = 5'b11111;

  // Bit positions of each layer in the mask
  localparam int COUCHE_CADRE    = 0;
  localparam int COUCHE_BRIQUES  = 1;
  localparam int COUCHE_RAQUETTE = 2;
  localparam int COUCHE_BALLE    = 3;

  // Fixed priority: balle > raquette > briques > cadre; zero means transparent.
  function automatic couleur_t arbitre(input couleur_t balle,
                                       input couleur_t raquette,
                                       input couleur_t briques,
                                       input couleur_t cadre);
    couleur_t res;
    if (balle != TRANSPARENT)         res = balle;
    else if (raquette != TRANSPARENT) res = raquette;
    else if (briques != TRANSPARENT)  res = briques;
    else if (cadre != TRANSPARENT)    res = cadre;
    else                              res = NOIR;
    return res;
  endfunction

endpackage

// File: rtl/vga_compteurs.sv
// vga_compteurs: hpos/vpos raster counters with wrap logic and the one-clock
// fin_trame strobe marking the start of vertical blanking.
module vga_compteurs
  import vga_pkg::*;
#(
  parameter int H_TOTAL   = DEF_H_TOTAL,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_TOTAL   = DEF_V_TOTAL
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] hpos,
  output logic [10:0] vpos,
  output logic        fin_trame
);

  logic [10:0] hpos_reg;
  logic [10:0] vpos_reg;
  logic        arrivee_reg;
  logic        fin_trame_reg;
  logic        fin_ligne;
  logic        fin_image;
  logic        vers_blanking;

  assign fin_ligne     = (hpos_reg == 11'(H_TOTAL - 1));
  assign fin_image     = (vpos_reg == 11'(V_TOTAL - 1));
  assign vers_blanking = fin_ligne && (vpos_reg == 11'(V_VISIBLE - 1));

  // Raster counters: hpos wraps every line, vpos steps on each hpos wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_reg <= '0;
      vpos_reg <= '0;
    end else if (pix_en) begin
      if (fin_ligne) begin
        hpos_reg <= '0;
        vpos_reg <= fin_image ? 11'd0 : vpos_reg + 11'd1;
      end else begin
        hpos_reg <= hpos_reg + 11'd1;
      end
    end
  end

  // arrivee_reg flags the first clock at (0, V_VISIBLE); fin_trame follows one
  // clock later so it lines up with the registered pixel outputs of that pixel.
  // Driven by the transition, not the position, so a stall cannot repeat it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arrivee_reg   <= 1'b0;
      fin_trame_reg <= 1'b0;
    end else begin
      arrivee_reg   <= pix_en && vers_blanking;
      fin_trame_reg <= arrivee_reg;
    end
  end

  assign hpos      = hpos_reg;
  assign vpos      = vpos_reg;
  assign fin_trame = fin_trame_reg;

endmodule

// File: rtl/vga_sequenceur.sv
// vga_sequenceur: 640x480 VGA pixel pipeline sequencer. Drives the raster
// counters, arbitrates the four layer colours and registers colour, syncs and
// visible together. Optional VGA_MASQUE_EN adds a per-frame layer mask input.
module vga_sequenceur
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  output logic [10:0] hpos,
  output logic [10:0] vpos,
  input  logic [4:0]  couleur_cadre,
  input  logic [4:0]  couleur_briques,
  input  logic [4:0]  couleur_raquette,
  input  logic [4:0]  couleur_balle,
`ifdef VGA_MASQUE_EN
  input  logic [3:0]  masque_in,
`endif
  output logic [4:0]  couleur,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        visible,
  output logic        fin_trame
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_DEBUT = H_VISIBLE + H_FRONT;
  localparam int HS_FIN   = HS_DEBUT + H_SYNC;
  localparam int VS_DEBUT = V_VISIBLE + V_FRONT;
  localparam int VS_FIN   = VS_DEBUT + V_SYNC;

  vga_compteurs #(
    .H_TOTAL   (H_TOTAL),
    .V_VISIBLE (V_VISIBLE),
    .V_TOTAL   (V_TOTAL)
  ) u_compteurs (
    .clk       (clk),
    .reset     (reset),
    .pix_en    (pix_en),
    .hpos      (hpos),
    .vpos      (vpos),
    .fin_trame (fin_trame)
  );

  logic [3:0] masque;

`ifdef VGA_MASQUE_EN
  logic [3:0] masque_reg;
  logic       debut_trame;

  assign debut_trame = pix_en && (hpos == 11'(H_TOTAL - 1)) && (vpos == 11'(V_TOTAL - 1));

  // Mask reloads only on the wrap to (0,0) so a frame never mixes two masks
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            masque_reg <= 4'b1111;
    else if (debut_trame) masque_reg <= masque_in;
  end

  assign masque = masque_reg;
`else
  assign masque = 4'b1111;
`endif

  logic [3:0][4:0] couches;
  logic [3:0][4:0] couches_masquees;

  assign couches[COUCHE_CADRE]    = couleur_cadre;
  assign couches[COUCHE_BRIQUES]  = couleur_briques;
  assign couches[COUCHE_RAQUETTE] = couleur_raquette;
  assign couches[COUCHE_BALLE]    = couleur_balle;

  // A disabled layer looks transparent to the arbiter
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_masque
      assign couches_masquees[gi] = masque[gi] ? couches[gi] : TRANSPARENT;
    end
  endgenerate

  logic       act;
  logic [4:0] couleur_next;
  logic       hsync_n_next;
  logic       vsync_n_next;
  logic [4:0] couleur_reg;
  logic       hsync_n_reg;
  logic       vsync_n_reg;
  logic       visible_reg;

  // Next pixel values decoded from the current raster position
  always_comb begin
    act          = (hpos < 11'(H_VISIBLE)) && (vpos < 11'(V_VISIBLE));
    couleur_next = NOIR;
    if (act) begin
      couleur_next = arbitre(couches_masquees[COUCHE_BALLE],
                             couches_masquees[COUCHE_RAQUETTE],
                             couches_masquees[COUCHE_BRIQUES],
                             couches_masquees[COUCHE_CADRE]);
    end
    hsync_n_next = !((hpos >= 11'(HS_DEBUT)) && (hpos < 11'(HS_FIN)));
    vsync_n_next = !((vpos >= 11'(VS_DEBUT)) && (vpos < 11'(VS_FIN)));
  end

  // Output stage: one pix_en of latency, all outputs describe the same pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      couleur_reg <= NOIR;
      hsync_n_reg <= 1'b1;
      vsync_n_reg <= 1'b1;
      visible_reg <= 1'b0;
    end else if (pix_en) begin
      couleur_reg <= couleur_next;
      hsync_n_reg <= hsync_n_next;
      vsync_n_reg <= vsync_n_next;
      visible_reg <= act;
    end
  end

  assign couleur = couleur_reg;
  assign hsync_n = hsync_n_reg;
  assign vsync_n = vsync_n_reg;
  assign visible = visible_reg;

endmodule

// File: tb/tb_vga_sequenceur.sv
// tb_vga_sequenceur: directed self-checking bench for vga_sequenceur.
// Horizontal timing uses the 640x480 defaults; the vertical timing is shrunk
// (8 visible, 2 front, 2 sync, 2 back = 14 lines) to keep whole frames short.
module tb_vga_sequenceur;
  import vga_pkg::*;

  localparam int TV_VISIBLE = 8;
  localparam int TV_FRONT   = 2;
  localparam int TV_SYNC    = 2;
  localparam int TV_BACK    = 2;
  localparam int LIGNE      = 800;
  localparam int TRAME      = LIGNE * 14;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic [4:0]  c_cadre;
  logic [4:0]  c_briques;
  logic [4:0]  c_raquette;
  logic [4:0]  c_balle;
  logic [4:0]  couleur;
  logic        hsync_n;
  logic        vsync_n;
  logic        visible;
  logic        fin_trame;
`ifdef VGA_MASQUE_EN
  logic [3:0]  masque_in;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  vga_sequenceur #(
    .H_VISIBLE (DEF_H_VISIBLE),
    .H_FRONT   (DEF_H_FRONT),
    .H_SYNC    (DEF_H_SYNC),
    .H_BACK    (DEF_H_BACK),
    .V_VISIBLE (TV_VISIBLE),
    .V_FRONT   (TV_FRONT),
    .V_SYNC    (TV_SYNC),
    .V_BACK    (TV_BACK)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pix_en           (pix_en),
    .hpos             (hpos),
    .vpos             (vpos),
    .couleur_cadre    (c_cadre),
    .couleur_briques  (c_briques),
    .couleur_raquette (c_raquette),
    .couleur_balle    (c_balle),
`ifdef VGA_MASQUE_EN
    .masque_in        (masque_in),
`endif
    .couleur          (couleur),
    .hsync_n          (hsync_n),
    .vsync_n          (vsync_n),
    .visible          (visible),
    .fin_trame        (fin_trame)
  );

  // one clock, then sample 1 time unit after the edge
  task automatic pas();
    @(posedge clk);
    #1;
  endtask

  // run with pix_en=1 until the counters sit at (h,v); ok=0 if the budget expires
  task automatic aller_a(input int h, input int v, output bit ok);
    int n;
    n = 0;
    pix_en = 1'b1;
    while (!(hpos == 11'(h) && vpos == 11'(v)) && n < 30000) begin
      pas();
      n++;
    end
    ok = (hpos == 11'(h) && vpos == 11'(v));
  endtask

  task automatic couches(input logic [4:0] cad, input logic [4:0] bri,
                         input logic [4:0] raq, input logic [4:0] bal);
    c_cadre = cad; c_briques = bri; c_raquette = raq; c_balle = bal;
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1; pix_en = 1'b0;
    couches(5'd0, 5'd0, 5'd0, 5'd0);
    #2;
    checks++;
    if ({hpos, vpos, couleur, hsync_n, vsync_n, visible, fin_trame} !==
        {11'd0, 11'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_init: got h=%0d v=%0d c=%b hs=%b vs=%b vis=%b ft=%b, required 0 0 00000 1 1 0 0",
               hpos, vpos, couleur, hsync_n, vsync_n, visible, fin_trame);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    c_cadre = JAUNE;
    aller_a(300, 5, ok);
    checks++;
    if (!ok) $display("FAIL reach_300_5: got h=%0d v=%0d, required 300 5", hpos, vpos);
    else passed++;
    checks++;
    if (couleur !== JAUNE || visible !== 1'b1)
      $display("FAIL pre_reset_pixel: got c=%b vis=%b, required 11000 1", couleur, visible);
    else passed++;
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({hpos, vpos, couleur, hsync_n, vsync_n, visible, fin_trame} !==
        {11'd0, 11'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_async: got h=%0d v=%0d c=%b hs=%b vs=%b vis=%b ft=%b, required 0 0 00000 1 1 0 0",
               hpos, vpos, couleur, hsync_n, vsync_n, visible, fin_trame);
    else passed++;
    c_cadre = 5'd0;
    @(negedge clk);
    reset = 1'b0;
    pix_en = 1'b1;
  endtask

  task automatic test_hsync();
    int t656, tlow, thigh, tz1, tz2;
    t656 = -1; tlow = -1; thigh = -1; tz1 = -1; tz2 = -1;
    pix_en = 1'b1;
    for (int k = 0; k < 2 * LIGNE; k++) begin
      pas();
      if (hpos == 11'd656 && t656 < 0) t656 = k;
      if (hsync_n == 1'b0 && tlow < 0) tlow = k;
      if (hsync_n == 1'b1 && tlow >= 0 && thigh < 0) thigh = k;
      if (hpos == 11'd0) begin
        if (tz1 < 0) tz1 = k;
        else if (tz2 < 0) tz2 = k;
      end
    end
    checks++;
    if (t656 < 0 || tlow - t656 != 1)
      $display("FAIL hsync_start: got low at %0d with hpos=656 at %0d, required 1 clk later", tlow, t656);
    else passed++;
    checks++;
    if (tlow < 0 || thigh - tlow != 96)
      $display("FAIL hsync_width: got %0d, required 96", thigh - tlow);
    else passed++;
    checks++;
    if (tz1 < 0 || tz2 - tz1 != LIGNE)
      $display("FAIL line_period: got %0d, required %0d", tz2 - tz1, LIGNE);
    else passed++;
  endtask

  task automatic test_arbitrage();
    bit ok;
    couches(5'd0, 5'd0, 5'd0, 5'd0);
    aller_a(100, 5, ok);
    checks++;
    if (!ok) $display("FAIL reach_100_5: got h=%0d v=%0d, required 100 5", hpos, vpos);
    else passed++;
    couches(5'b11000, 5'b10101, 5'b00000, 5'b00111);
    pas();
    checks++;
    if (couleur !== 5'b00111 || visible !== 1'b1)
      $display("FAIL arb_balle: got c=%b vis=%b, required 00111 1", couleur, visible);
    else passed++;
    c_balle = 5'd0;
    pas();
    checks++;
    if (couleur !== 5'b10101) $display("FAIL arb_briques: got %b, required 10101", couleur);
    else passed++;
    c_raquette = 5'b01010;
    pas();
    checks++;
    if (couleur !== 5'b01010) $display("FAIL arb_raquette: got %b, required 01010", couleur);
    else passed++;
    couches(5'b11000, 5'd0, 5'd0, 5'd0);
    pas();
    checks++;
    if (couleur !== 5'b11000) $display("FAIL arb_cadre: got %b, required 11000", couleur);
    else passed++;
    couches(5'd0, 5'd0, 5'd0, 5'd0);
    pas();
    checks++;
    if (couleur !== 5'b00000 || visible !== 1'b1)
      $display("FAIL arb_transparent: got c=%b vis=%b, required 00000 1", couleur, visible);
    else passed++;
  endtask

  task automatic test_hors_zone();
    bit ok;
    couches(BLANC, BLANC, BLANC, BLANC);
    aller_a(639, 5, ok);
    pas();
    checks++;
    if (!ok || couleur !== BLANC || visible !== 1'b1)
      $display("FAIL last_visible_col: got c=%b vis=%b, required 11111 1", couleur, visible);
    else passed++;
    pas();
    checks++;
    if (couleur !== 5'd0 || visible !== 1'b0)
      $display("FAIL first_blank_col: got c=%b vis=%b, required 00000 0", couleur, visible);
    else passed++;
    aller_a(700, 5, ok);
    pas();
    checks++;
    if (!ok || couleur !== 5'd0 || visible !== 1'b0 || hsync_n !== 1'b0)
      $display("FAIL hpos_700: got c=%b vis=%b hs=%b, required 00000 0 0", couleur, visible, hsync_n);
    else passed++;
  endtask

  task automatic test_fin_trame_pause();
    bit ok;
    int pulses;
    aller_a(0, 8, ok);
    checks++;
    if (!ok || fin_trame !== 1'b0)
      $display("FAIL fin_trame_arrival: got h=%0d v=%0d ft=%b, required 0 8 0", hpos, vpos, fin_trame);
    else passed++;
    pix_en = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      pas();
      if (fin_trame === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) $display("FAIL fin_trame_paused: got %0d pulses, required 1", pulses);
    else passed++;
    checks++;
    if (hpos !== 11'd0 || vpos !== 11'd8)
      $display("FAIL hold_counters: got h=%0d v=%0d, required 0 8", hpos, vpos);
    else passed++;
    pix_en = 1'b1;
  endtask

  task automatic test_bord_vertical();
    bit ok;
    couches(BLANC, BLANC, BLANC, BLANC);
    aller_a(5, 8, ok);
    pas();
    checks++;
    if (!ok || couleur !== 5'd0 || visible !== 1'b0)
      $display("FAIL first_blank_line: got c=%b vis=%b, required 00000 0", couleur, visible);
    else passed++;
  endtask

  task automatic test_vsync_trame();
    int ta, tb, t10, tlow, thigh, tfin, pulses;
    ta = -1; tb = -1; t10 = -1; tlow = -1; thigh = -1; tfin = -1; pulses = 0;
    pix_en = 1'b1;
    for (int k = 0; k < 2 * TRAME + 2 * LIGNE && tb < 0; k++) begin
      pas();
      if (hpos == 11'd0 && vpos == 11'd8) begin
        if (ta < 0) ta = k;
        else tb = k;
      end
      if (ta >= 0 && tb < 0 && fin_trame === 1'b1) begin
        pulses++;
        if (tfin < 0) tfin = k;
      end
      if (hpos == 11'd0 && vpos == 11'd10 && t10 < 0) t10 = k;
      if (vsync_n == 1'b0 && tlow < 0) tlow = k;
      if (vsync_n == 1'b1 && tlow >= 0 && thigh < 0) thigh = k;
    end
    checks++;
    if (t10 < 0 || tlow - t10 != 1)
      $display("FAIL vsync_start: got low at %0d with vpos=10 at %0d, required 1 clk later", tlow, t10);
    else passed++;
    checks++;
    if (tlow < 0 || thigh - tlow != 2 * LIGNE)
      $display("FAIL vsync_width: got %0d, required %0d", thigh - tlow, 2 * LIGNE);
    else passed++;
    checks++;
    if (ta < 0 || tb - ta != TRAME)
      $display("FAIL frame_period: got %0d, required %0d", tb - ta, TRAME);
    else passed++;
    checks++;
    if (pulses != 1 || tfin - ta != 1)
      $display("FAIL fin_trame_frame: got %0d pulses at offset %0d, required 1 at offset 1", pulses, tfin - ta);
    else passed++;
  endtask

  task automatic test_pix_en_alterne();
    int tz1, tz2, erreurs;
    logic [10:0] ph, pv;
    logic [4:0]  pc;
    logic        phs, pvs, pvis, en;
    tz1 = -1; tz2 = -1; erreurs = 0;
    couches(BLANC, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < 4 * LIGNE + 200; k++) begin
      en = (k % 2 == 0);
      pix_en = en;
      ph = hpos; pv = vpos; pc = couleur; phs = hsync_n; pvs = vsync_n; pvis = visible;
      pas();
      if (!en && {hpos, vpos, couleur, hsync_n, vsync_n, visible} !== {ph, pv, pc, phs, pvs, pvis})
        erreurs++;
      if (hpos == 11'd0 && ph != 11'd0) begin
        if (tz1 < 0) tz1 = k;
        else if (tz2 < 0) tz2 = k;
      end
    end
    pix_en = 1'b1;
    checks++;
    if (erreurs != 0) $display("FAIL hold_pix_en_low: got %0d changes, required 0", erreurs);
    else passed++;
    checks++;
    if (tz1 < 0 || tz2 - tz1 != 2 * LIGNE)
      $display("FAIL line_period_half_rate: got %0d, required %0d", tz2 - tz1, 2 * LIGNE);
    else passed++;
  endtask

`ifdef VGA_MASQUE_EN
  task automatic test_masque();
    bit ok;
    couches(5'b11000, 5'b10101, 5'b01010, 5'b00111);
    aller_a(100, 3, ok);
    masque_in = 4'b0111;
    pas();
    checks++;
    if (!ok || couleur !== 5'b00111)
      $display("FAIL mask_same_frame: got %b, required 00111", couleur);
    else passed++;
    aller_a(100, 6, ok);
    pas();
    checks++;
    if (!ok || couleur !== 5'b00111)
      $display("FAIL mask_later_line: got %b, required 00111", couleur);
    else passed++;
    aller_a(100, 2, ok);
    pas();
    checks++;
    if (!ok || couleur !== 5'b01010)
      $display("FAIL mask_next_frame: got %b, required 01010", couleur);
    else passed++;
  endtask
`endif

  initial begin
`ifdef VGA_MASQUE_EN
    masque_in = 4'b1111;
`endif
    test_reset();
    test_hsync();
    test_arbitrage();
    test_hors_zone();
    test_fin_trame_pause();
    test_bord_vertical();
    test_vsync_trame();
    test_pix_en_alterne();
`ifdef VGA_MASQUE_EN
    test_masque();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
